// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single memory controller.
// One transaction in flight: IDLE -> ISSUE -> BUSY -> DONE, with a BUSY timeout.
module mem_port_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     rw0,
    input  logic                     rw1,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     ack0,
    output logic                     ack1,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     err,
    output logic                     busy,
    output logic                     mc_enable,
    output logic                     mc_rw,
    output logic [ADDRESS_WIDTH-1:0] mc_address,
    output logic [DATA_WIDTH-1:0]    mc_data_in,
    input  logic [DATA_WIDTH-1:0]    mc_data_out,
    input  logic                     mc_wait
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StDone} state_e;

    state_e                   r_state;
    logic                     r_last_grant;
    logic                     r_owner;
    logic                     r_seen_wait;
    logic [CNT_W-1:0]         r_count;
    logic                     r_mc_enable;
    logic                     r_mc_rw;
    logic [ADDRESS_WIDTH-1:0] r_mc_address;
    logic [DATA_WIDTH-1:0]    r_mc_data_in;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_err;
    logic                     r_ack0;
    logic                     r_ack1;

    logic w_pick0;
    logic w_pick1;
    logic w_idle;
    logic w_complete;
    logic w_timeout;

    // On a tie the port that did not win last time goes first.
    assign w_pick0    = req0 && (!req1 || r_last_grant);
    assign w_pick1    = req1 && (!req0 || !r_last_grant);
    assign w_idle     = reset_n && (r_state == StIdle);
    assign gnt0       = w_idle && w_pick0;
    assign gnt1       = w_idle && w_pick1;
    assign w_complete = r_seen_wait && !mc_wait;
    assign w_timeout  = (r_count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_seen_wait  <= 1'b0;
            r_count      <= '0;
            r_mc_enable  <= 1'b0;
            r_mc_rw      <= 1'b0;
            r_mc_address <= '0;
            r_mc_data_in <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
        end else begin
            r_mc_enable <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (gnt0 || gnt1) begin
                        r_mc_rw      <= gnt1 ? rw1 : rw0;
                        r_mc_address <= gnt1 ? addr1 : addr0;
                        r_mc_data_in <= gnt1 ? wdata1 : wdata0;
                        r_owner      <= gnt1;
                        r_last_grant <= gnt1;
                        r_mc_enable  <= 1'b1;
                        r_state      <= StIssue;
                    end
                end
                StIssue: begin
                    r_count     <= '0;
                    r_seen_wait <= 1'b0;
                    r_state     <= StBusy;
                end
                StBusy: begin
                    if (w_complete) begin
                        if (!r_mc_rw) begin
                            r_rdata <= mc_data_out;
                        end
                        r_ack0  <= !r_owner;
                        r_ack1  <= r_owner;
                        r_state <= StDone;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_ack0  <= !r_owner;
                        r_ack1  <= r_owner;
                        r_state <= StDone;
                    end else begin
                        r_count <= r_count + 1'b1;
                        if (mc_wait) begin
                            r_seen_wait <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy       = (r_state != StIdle);
    assign mc_enable  = r_mc_enable;
    assign mc_rw      = r_mc_rw;
    assign mc_address = r_mc_address;
    assign mc_data_in = r_mc_data_in;
    assign rdata      = r_rdata;
    assign err        = r_err;
    assign ack0       = r_ack0;
    assign ack1       = r_ack1;

endmodule
